// File: rtl/servant_spi_ram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : servant_spi_ram_responder_pkg
// Brief  : Shared opcodes, FSM state encoding and bit-count limits for the
//          SPI RAM responder.
// Rev    : 1.0  initial release
// ============================================================================
package servant_spi_ram_responder_pkg;

  // Opcodes shared with the SPI master side
  localparam logic [7:0] CMD_READ_DEFAULT  = 8'h03;
  localparam logic [7:0] CMD_WRITE_DEFAULT = 8'h02;

  // Last bit index of each frame field (bit counter counts 0..N)
  localparam logic [4:0] CMD_BIT_LAST  = 5'd7;
  localparam logic [4:0] ADDR_BIT_LAST = 5'd23;
  localparam logic [4:0] DATA_BIT_LAST = 5'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_READ   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_IGNORE = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/servant_spi_sync.sv
`default_nettype none
// ============================================================================
// Module : servant_spi_sync
// Brief  : Multi-stage input synchronizer with optional rise/fall pulses
//          derived from the synchronized level.
// Rev    : 1.0  initial release
// ============================================================================
module servant_spi_sync #(
  parameter int   STAGES    = 2,
  parameter bit   EDGES     = 1'b1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the synchronizer chain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= {STAGES{RESET_VAL}};
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign level_o = sync_q[STAGES-1];

  generate
    if (EDGES) begin : g_edges
      logic prev_q;

      // Remember the previous synchronized level for edge detection
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) prev_q <= RESET_VAL;
        else       prev_q <= sync_q[STAGES-1];
      end

      assign rise_o =  sync_q[STAGES-1] & ~prev_q;
      assign fall_o = ~sync_q[STAGES-1] &  prev_q;
    end else begin : g_no_edges
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/servant_spi_ram_responder.sv
`default_nettype none
// ============================================================================
// Module : servant_spi_ram_responder
// Brief  : SPI mode-0 target turning read/write frames into byte accesses on
//          a synchronous byte RAM. All SPI pins are oversampled on wb_clk.
// Rev    : 1.0  initial release
// ============================================================================
module servant_spi_ram_responder
  import servant_spi_ram_responder_pkg::*;
#(
  parameter int         ADDRESS_WIDTH = 18,
  parameter logic [7:0] CMD_READ      = CMD_READ_DEFAULT,
  parameter logic [7:0] CMD_WRITE     = CMD_WRITE_DEFAULT,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst,
  input  logic                     i_spi_sck,
  input  logic                     i_spi_cs_n,
  input  logic                     i_spi_mosi,
  output logic                     o_spi_miso,
  output logic [ADDRESS_WIDTH-1:0] o_ram_addr,
  output logic [7:0]               o_ram_wdata,
  output logic                     o_ram_we,
  output logic                     o_ram_re,
  input  logic [7:0]               i_ram_rdata,
  output logic                     o_busy
);

  logic w_sck_level_unused, w_sck_rise, w_sck_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall_unused;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  servant_spi_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b1), .RESET_VAL(1'b0)) u_sync_sck (
    .clk_i(wb_clk), .rst_i(wb_rst), .d_i(i_spi_sck),
    .level_o(w_sck_level_unused), .rise_o(w_sck_rise), .fall_o(w_sck_fall)
  );

  // Chip select idles deasserted so a reset never looks like a frame start
  servant_spi_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b1), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i(wb_clk), .rst_i(wb_rst), .d_i(i_spi_cs_n),
    .level_o(w_cs_level), .rise_o(w_cs_rise), .fall_o(w_cs_fall_unused)
  );

  servant_spi_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b0), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(wb_clk), .rst_i(wb_rst), .d_i(i_spi_mosi),
    .level_o(w_mosi), .rise_o(w_mosi_rise_unused), .fall_o(w_mosi_fall_unused)
  );

  state_e                   state_q, state_d;
  logic [4:0]               bitcnt_q, bitcnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]               rx_q, rx_d;
  logic [7:0]               tx_q, tx_d;
  logic [7:0]               wdata_q, wdata_d;
  logic                     miso_q, miso_d;
  logic                     we_q, we_d;
  logic                     re_q, re_d;
  logic                     load_q, load_d;
  logic                     rd_cmd_q, rd_cmd_d;

  logic [7:0]               w_rx_shift;
  logic [7:0]               w_tx_cur;
  logic [ADDRESS_WIDTH-1:0] w_addr_shift;

  assign w_rx_shift   = {rx_q[6:0], w_mosi};
  assign w_addr_shift = {addr_q[ADDRESS_WIDTH-2:0], w_mosi};
  // Read data arriving this cycle takes priority over the idle TX register
  assign w_tx_cur     = load_q ? i_ram_rdata : tx_q;

  // State register and datapath registers
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= 5'd0;
      addr_q   <= '0;
      rx_q     <= 8'd0;
      tx_q     <= 8'd0;
      wdata_q  <= 8'd0;
      miso_q   <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      load_q   <= 1'b0;
      rd_cmd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      addr_q   <= addr_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      wdata_q  <= wdata_d;
      miso_q   <= miso_d;
      we_q     <= we_d;
      re_q     <= re_d;
      load_q   <= load_d;
      rd_cmd_q <= rd_cmd_d;
    end
  end

  // Next-state logic: frame decoding, counters, shift registers and strobes
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    addr_d   = we_q ? addr_q + ADDRESS_WIDTH'(1) : addr_q;
    rx_d     = rx_q;
    tx_d     = w_tx_cur;
    wdata_d  = wdata_q;
    miso_d   = miso_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    load_d   = re_q;
    rd_cmd_d = rd_cmd_q;

    if (w_cs_rise) begin
      // End of frame wins over any coincident SCK edge
      state_d  = ST_IDLE;
      bitcnt_d = 5'd0;
      miso_d   = 1'b0;
      load_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!w_cs_level) begin
            state_d  = ST_CMD;
            bitcnt_d = 5'd0;
            rx_d     = 8'd0;
          end
        end
        ST_CMD: begin
          if (w_sck_rise) begin
            rx_d = w_rx_shift;
            if (bitcnt_q == CMD_BIT_LAST) begin
              bitcnt_d = 5'd0;
              if (w_rx_shift == CMD_READ) begin
                rd_cmd_d = 1'b1;
                state_d  = ST_ADDR;
              end else if (w_rx_shift == CMD_WRITE) begin
                rd_cmd_d = 1'b0;
                state_d  = ST_ADDR;
              end else begin
                state_d  = ST_IGNORE;
              end
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end
        ST_ADDR: begin
          if (w_sck_rise) begin
            addr_d = w_addr_shift;
            if (bitcnt_q == ADDR_BIT_LAST) begin
              bitcnt_d = 5'd0;
              rx_d     = 8'd0;
              if (rd_cmd_q) begin
                state_d = ST_READ;
                re_d    = 1'b1;
              end else begin
                state_d = ST_WRITE;
              end
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end
        ST_READ: begin
          if (w_sck_fall) begin
            miso_d = w_tx_cur[7];
            tx_d   = {w_tx_cur[6:0], 1'b0};
          end
          if (w_sck_rise) begin
            if (bitcnt_q == DATA_BIT_LAST) begin
              bitcnt_d = 5'd0;
              addr_d   = addr_q + ADDRESS_WIDTH'(1);
              re_d     = 1'b1;
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end
        ST_WRITE: begin
          if (w_sck_rise) begin
            rx_d = w_rx_shift;
            if (bitcnt_q == DATA_BIT_LAST) begin
              bitcnt_d = 5'd0;
              wdata_d  = w_rx_shift;
              we_d     = 1'b1;
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end
        ST_IGNORE: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign o_spi_miso  = miso_q;
  assign o_ram_addr  = addr_q;
  assign o_ram_wdata = wdata_q;
  assign o_ram_we    = we_q;
  assign o_ram_re    = re_q;
  assign o_busy      = ~w_cs_level;

endmodule
`default_nettype wire
